reg_file: RTL and testbench
===========================

# reg_file

Architectural register file with rename tags, directly downstream of the ROB commit port and upstream of the decoder's operand query. Holds 32 committed register values plus, per register, a busy bit and the ROB position of the youngest in-flight writer. The decoder uses this tag to query the ROB for not-yet-committed values. Commit writes from the ROB update values and retire tags. A ROB rollback discards all rename state.

## Interface
- REG_NUM, 32: number of architectural registers; x0 is hard-wired zero.
- REG_POS_W, 5: register index width.
- ROB_POS_W, 4: ROB position width (16-entry ROB).
- DATA_W, 32: register data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock domain; asynchronous, active-low (asserted at 0).
- rdy  in  1  global enable; when 0, all state holds.
- rollback  in  1  ROB misprediction flush.
- issue  in  1  an instruction is being issued this cycle.
- issue_rd  in  REG_POS_W  destination register of the issued instruction.
- issue_rob_pos  in  ROB_POS_W  ROB slot allocated to the issued instruction.
- reg_write  in  1  ROB commit writes a register.
- reg_rd  in  REG_POS_W  committed destination.
- reg_val  in  DATA_W  committed value.
- commit_rob_pos  in  ROB_POS_W  ROB slot being committed.
- rs1  in  REG_POS_W  source-1 index from the decoder.
- rs1_val  out  DATA_W  source-1 value.
- rs1_busy  out  1  source-1 pending in the ROB.
- rs1_rob_pos  out  ROB_POS_W  source-1 producer tag, valid when rs1_busy=1.
- rs2, rs2_val, rs2_busy, rs2_rob_pos: identical to the rs1 group.

## Operation
- State per register r: val[r], busy[r], tag[r].
- Reset (rst=0, asynchronous): all val, busy and tag are 0. Outputs are combinational from this state, so they read 0/0/0 during reset.
- Commit write (rdy=1, reg_write=1, reg_rd≠0):
  - val[reg_rd] <= reg_val.
  - busy[reg_rd] <= 0 only if busy=1 and tag[reg_rd]==commit_rob_pos.
  - Otherwise a younger writer owns the register and busy/tag are untouched.
- Issue (rdy=1, issue=1, issue_rd≠0, rollback=0): busy[issue_rd] <= 1 and tag[issue_rd] <= issue_rob_pos.
- Issue and commit to the same register in the same cycle: issue wins for busy/tag, and val is still written.
- Rollback (rdy=1, rollback=1):
  - All busy bits are cleared and issue is ignored.
  - A coincident reg_write (e.g. a committing JALR) still writes val.
- Writes to x0 are dropped. Reads of x0 always return val=0, busy=0, rob_pos=0.
- Read port (combinational, per source):
  - If busy[rs]=1, reg_write=1, reg_rd==rs and tag[rs]==commit_rob_pos, forward reg_val with busy=0.
  - Otherwise return val[rs], busy[rs] and tag[rs].
- Reads reflect pre-issue state. An instruction whose rs equals its own rd sees the previous producer, not itself.

## Timing
- Issue and commit effects become visible on the read ports the cycle after the edge.
- Commit-to-read forwarding has zero latency (same cycle).
- Rollback takes one cycle; from the next cycle every register reads non-busy.
- rdy=0 freezes state, but read ports stay live.
- No handshakes and no back-pressure: inputs are assumed single-cycle pulses from the ROB and decoder.

## Structure
- Widths (REG_POS_W, ROB_POS_W, DATA_W, REG_NUM) come from the shared size header used by the ROB and decoder, not local literals.
- One sub-module, reg_file_rd_port: the x0 check plus the commit-forwarding mux. It is instantiated twice, for rs1 and rs2.
- The state arrays and update logic stay in reg_file.

## Test plan
- Reset: drive rst=0 mid-run with busy registers → all reads return 0/0/0 immediately; after release, x5 reads val=0, busy=0.
- Rename then commit:
  - issue rd=5, rob_pos=3 → next cycle rs1=5 gives busy=1, rob_pos=3.
  - commit reg_rd=5, pos=3, val=0xDEADBEEF → same cycle busy=0, val=0xDEADBEEF.
  - next cycle val is held.
- Stale commit: issue x7@2, then issue x7@6, then commit x7@2 val=0x11 → val=0x11, busy stays 1, tag stays 6.
- Same-cycle collision: issue x9@4 while committing x9@1 (tag was 1) val=0x22 → next cycle busy=1, tag=4, val=0x22.
- Rollback with JALR commit: x3 and x8 busy; rollback=1 with reg_write x1 val=0x80 → next cycle every register non-busy, x1=0x80, and an issue in the rollback cycle is ignored.
- x0 and rdy: issue/commit to x0 val=0x55 → x0 reads 0, not busy. With rdy=0, issue x4@5 → x4 stays non-busy.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared sizes and payload types for the architectural register file,
// kept in step with the ROB and decoder.
package reg_file_pkg;

  localparam int unsigned REG_NUM   = 32;
  localparam int unsigned REG_POS_W = 5;
  localparam int unsigned ROB_POS_W = 4;
  localparam int unsigned DATA_W    = 32;

  typedef logic [REG_POS_W-1:0] reg_pos_t;
  typedef logic [ROB_POS_W-1:0] rob_pos_t;
  typedef logic [DATA_W-1:0]    data_t;

  // Commit write presented by the ROB this cycle
  typedef struct packed {
    logic     reg_write;
    reg_pos_t reg_rd;
    data_t    reg_val;
    rob_pos_t rob_pos;
  } commit_t;

  // Operand answer returned to the decoder
  typedef struct packed {
    data_t    val;
    logic     busy;
    rob_pos_t rob_pos;
  } rd_resp_t;

endpackage

// File: rtl/reg_file_if.sv
// Issue, commit, rollback and operand-query signals between the ROB/decoder
// (master) and the register file (slave).
interface reg_file_if;
  import reg_file_pkg::*;

  logic     rollback;
  logic     issue;
  reg_pos_t issue_rd;
  rob_pos_t issue_rob_pos;
  logic     reg_write;
  reg_pos_t reg_rd;
  data_t    reg_val;
  rob_pos_t commit_rob_pos;

  reg_pos_t rs1;
  data_t    rs1_val;
  logic     rs1_busy;
  rob_pos_t rs1_rob_pos;
  reg_pos_t rs2;
  data_t    rs2_val;
  logic     rs2_busy;
  rob_pos_t rs2_rob_pos;

  modport master (
    output rollback, issue, issue_rd, issue_rob_pos,
    output reg_write, reg_rd, reg_val, commit_rob_pos,
    output rs1, rs2,
    input  rs1_val, rs1_busy, rs1_rob_pos,
    input  rs2_val, rs2_busy, rs2_rob_pos
  );

  modport slave (
    input  rollback, issue, issue_rd, issue_rob_pos,
    input  reg_write, reg_rd, reg_val, commit_rob_pos,
    input  rs1, rs2,
    output rs1_val, rs1_busy, rs1_rob_pos,
    output rs2_val, rs2_busy, rs2_rob_pos
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// One operand read port: x0 masking plus same-cycle forwarding of a commit
// that retires the register's current producer.
module reg_file_rd_port
  import reg_file_pkg::*;
(
  input  reg_pos_t rs,
  input  data_t    val_q,
  input  logic     busy_q,
  input  rob_pos_t tag_q,
  input  commit_t  commit,
  output rd_resp_t resp_c
);

  always_comb begin
    resp_c = '0;
    if (rs != '0) begin
      resp_c.val     = val_q;
      resp_c.busy    = busy_q;
      resp_c.rob_pos = tag_q;
      // Producer is committing right now: hand its value straight through
      if (busy_q && commit.reg_write && (commit.reg_rd == rs) &&
          (tag_q == commit.rob_pos)) begin
        resp_c.val  = commit.reg_val;
        resp_c.busy = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags; updated by ROB
// commits and decoder issues, flushed of rename state on rollback.
module reg_file
  import reg_file_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  reg_file_if.slave   bus
);

  data_t              val_q [REG_NUM];
  data_t              val_d [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  rob_pos_t           tag_q [REG_NUM];
  rob_pos_t           tag_d [REG_NUM];

  commit_t            commit_c;
  rd_resp_t           rd1_c;
  rd_resp_t           rd2_c;

  assign commit_c = {bus.reg_write, bus.reg_rd, bus.reg_val, bus.commit_rob_pos};

  // Next state: commit first, then rollback/issue so issue owns busy/tag
  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy) begin
      if (bus.reg_write && (bus.reg_rd != '0)) begin
        val_d[bus.reg_rd] = bus.reg_val;
        if (busy_q[bus.reg_rd] && (tag_q[bus.reg_rd] == bus.commit_rob_pos)) begin
          busy_d[bus.reg_rd] = 1'b0;
        end
      end
      if (bus.rollback) begin
        busy_d = '0;
      end else if (bus.issue && (bus.issue_rd != '0)) begin
        busy_d[bus.issue_rd] = 1'b1;
        tag_d[bus.issue_rd]  = bus.issue_rob_pos;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q  <= '{default: '0};
      busy_q <= '0;
      tag_q  <= '{default: '0};
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  reg_file_rd_port u_rd1 (
    .rs     (bus.rs1),
    .val_q  (val_q[bus.rs1]),
    .busy_q (busy_q[bus.rs1]),
    .tag_q  (tag_q[bus.rs1]),
    .commit (commit_c),
    .resp_c (rd1_c)
  );

  reg_file_rd_port u_rd2 (
    .rs     (bus.rs2),
    .val_q  (val_q[bus.rs2]),
    .busy_q (busy_q[bus.rs2]),
    .tag_q  (tag_q[bus.rs2]),
    .commit (commit_c),
    .resp_c (rd2_c)
  );

  assign bus.rs1_val     = rd1_c.val;
  assign bus.rs1_busy    = rd1_c.busy;
  assign bus.rs1_rob_pos = rd1_c.rob_pos;
  assign bus.rs2_val     = rd2_c.val;
  assign bus.rs2_busy    = rd2_c.busy;
  assign bus.rs2_rob_pos = rd2_c.rob_pos;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: the driver queues expected operand answers,
// a negedge monitor pops and compares them against the read ports.
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  reg_file_if bus ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       port;
    data_t    val;
    logic     busy;
    rob_pos_t pos;
    bit       chk_pos;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    checks   = 0;
  int    failures = 0;

  exp_t     e;
  string    nm;
  data_t    av;
  logic     ab;
  rob_pos_t ap;

  // Monitor: everything queued this cycle is checked at the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.port == 1) begin
        av = bus.rs1_val; ab = bus.rs1_busy; ap = bus.rs1_rob_pos;
      end else begin
        av = bus.rs2_val; ab = bus.rs2_busy; ap = bus.rs2_rob_pos;
      end
      checks++;
      if (av !== e.val || ab !== e.busy || (e.chk_pos && ap !== e.pos)) begin
        failures++;
        $display("FAIL %s: got val=%h busy=%b pos=%0d, want val=%h busy=%b pos=%0d%s",
                 nm, av, ab, ap, e.val, e.busy, e.pos, e.chk_pos ? "" : " (pos not checked)");
      end
    end
  end

  task automatic clear_pulses();
    bus.issue     = 1'b0;
    bus.reg_write = 1'b0;
    bus.rollback  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_pulses();
  endtask

  task automatic expect_rd(input int port, input reg_pos_t rs, input data_t v,
                           input logic b, input rob_pos_t p, input bit cp,
                           input string name);
    exp_t x;
    if (port == 1) bus.rs1 = rs;
    else           bus.rs2 = rs;
    x.port = port; x.val = v; x.busy = b; x.pos = p; x.chk_pos = cp;
    exp_q.push_back(x);
    name_q.push_back(name);
  endtask

  task automatic do_issue(input reg_pos_t rd, input rob_pos_t pos);
    bus.issue = 1'b1; bus.issue_rd = rd; bus.issue_rob_pos = pos;
  endtask

  task automatic do_commit(input reg_pos_t rd, input rob_pos_t pos, input data_t v);
    bus.reg_write = 1'b1; bus.reg_rd = rd; bus.commit_rob_pos = pos; bus.reg_val = v;
  endtask

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    clear_pulses();
    bus.issue_rd = '0; bus.issue_rob_pos = '0;
    bus.reg_rd = '0; bus.reg_val = '0; bus.commit_rob_pos = '0;
    bus.rs1 = '0; bus.rs2 = '0;

    // Power-on reset
    #1;
    expect_rd(1, 5'd5, 32'h0, 1'b0, 4'd0, 1'b1, "reset_x5");
    tick(); tick();
    rst = 1'b1;
    tick();

    // Rename then commit
    do_issue(5'd5, 4'd3);
    expect_rd(1, 5'd5, 32'h0, 1'b0, 4'd0, 1'b0, "pre_issue_x5");
    tick();
    expect_rd(1, 5'd5, 32'h0, 1'b1, 4'd3, 1'b1, "renamed_x5");
    tick();
    do_commit(5'd5, 4'd3, 32'hDEADBEEF);
    expect_rd(1, 5'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, "fwd_x5");
    tick();
    expect_rd(1, 5'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, "held_x5");
    tick();

    // Stale commit by an older writer
    do_issue(5'd7, 4'd2);
    tick();
    do_issue(5'd7, 4'd6);
    tick();
    do_commit(5'd7, 4'd2, 32'h11);
    expect_rd(2, 5'd7, 32'h0, 1'b1, 4'd6, 1'b1, "stale_no_fwd_x7");
    tick();
    expect_rd(2, 5'd7, 32'h11, 1'b1, 4'd6, 1'b1, "stale_x7");
    tick();

    // Same-cycle issue and commit to one register
    do_issue(5'd9, 4'd1);
    tick();
    do_issue(5'd9, 4'd4);
    do_commit(5'd9, 4'd1, 32'h22);
    expect_rd(1, 5'd9, 32'h22, 1'b0, 4'd0, 1'b0, "collide_fwd_x9");
    tick();
    expect_rd(1, 5'd9, 32'h22, 1'b1, 4'd4, 1'b1, "collide_x9");
    tick();

    // Rollback with a committing JALR
    do_issue(5'd3, 4'd7);
    tick();
    do_issue(5'd8, 4'd8);
    tick();
    do_issue(5'd1, 4'd9);
    expect_rd(1, 5'd3, 32'h0, 1'b1, 4'd7, 1'b1, "busy_x3");
    expect_rd(2, 5'd8, 32'h0, 1'b1, 4'd8, 1'b1, "busy_x8");
    tick();
    bus.rollback = 1'b1;
    do_commit(5'd1, 4'd9, 32'h80);
    do_issue(5'd10, 4'd10);
    tick();
    expect_rd(1, 5'd1, 32'h80, 1'b0, 4'd0, 1'b0, "rb_jalr_x1");
    expect_rd(2, 5'd10, 32'h0, 1'b0, 4'd0, 1'b0, "rb_issue_ignored_x10");
    tick();
    expect_rd(1, 5'd3, 32'h0, 1'b0, 4'd0, 1'b0, "rb_clear_x3");
    expect_rd(2, 5'd8, 32'h0, 1'b0, 4'd0, 1'b0, "rb_clear_x8");
    tick();
    expect_rd(1, 5'd7, 32'h11, 1'b0, 4'd0, 1'b0, "rb_clear_x7");
    expect_rd(2, 5'd9, 32'h22, 1'b0, 4'd0, 1'b0, "rb_clear_x9");
    tick();

    // x0 writes are dropped
    do_issue(5'd0, 4'd5);
    do_commit(5'd0, 4'd5, 32'h55);
    expect_rd(1, 5'd0, 32'h0, 1'b0, 4'd0, 1'b1, "x0_same_cycle");
    tick();
    expect_rd(1, 5'd0, 32'h0, 1'b0, 4'd0, 1'b1, "x0_rs1");
    expect_rd(2, 5'd0, 32'h0, 1'b0, 4'd0, 1'b1, "x0_rs2");
    tick();

    // rdy=0 freezes state but reads stay live
    rdy = 1'b0;
    do_issue(5'd4, 4'd5);
    do_commit(5'd5, 4'd0, 32'h99);
    expect_rd(1, 5'd9, 32'h22, 1'b0, 4'd0, 1'b0, "rdy0_read_live_x9");
    tick();
    rdy = 1'b1;
    expect_rd(1, 5'd4, 32'h0, 1'b0, 4'd0, 1'b0, "rdy0_no_issue_x4");
    expect_rd(2, 5'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, "rdy0_no_commit_x5");
    tick();

    // Mid-run asynchronous reset with a busy register
    do_issue(5'd12, 4'd2);
    tick();
    expect_rd(1, 5'd12, 32'h0, 1'b1, 4'd2, 1'b1, "busy_x12");
    tick();
    rst = 1'b0;
    expect_rd(1, 5'd12, 32'h0, 1'b0, 4'd0, 1'b1, "midreset_x12");
    expect_rd(2, 5'd5, 32'h0, 1'b0, 4'd0, 1'b1, "midreset_x5");
    tick();
    rst = 1'b1;
    tick();
    expect_rd(1, 5'd5, 32'h0, 1'b0, 4'd0, 1'b1, "post_reset_x5");
    expect_rd(2, 5'd12, 32'h0, 1'b0, 4'd0, 1'b1, "post_reset_x12");
    tick();
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
